mc_ctrl: RTL and testbench

Main control FSM for the multi-cycle MIPS core that replaces the single-cycle decoder inside `CPU`. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states and drives every write enable and mux select of the shared datapath (PC, IR, GRF, ALU, DM, NPC, EXT). Supported subset: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, nop.

---
 rtl/mc_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Main control FSM for the multi-cycle MIPS core: sequences FETCH/DECODE/EXEC/MEM/WB
// and drives every datapath enable and select. Define MC_MEM_WAIT_EN to stall MEM on mem_ready.
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       mem_we,
    output logic [1:0] alu_op,
    output logic       alu_src_b,
    output logic       ext_op,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic [1:0] npc_sel,
    output logic [2:0] state,
    output logic       instr_done
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        I_NONE, I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_JR
    } instr_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_OR  = 2'd2;
    localparam logic [1:0] ALU_LUI = 2'd3;

    localparam logic [1:0] DST_RT  = 2'd0;
    localparam logic [1:0] DST_RD  = 2'd1;
    localparam logic [1:0] DST_RA  = 2'd2;

    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_DM   = 2'd1;
    localparam logic [1:0] WD_PC   = 2'd2;

    localparam logic [1:0] NPC_SEQ    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_RS     = 2'd3;

    state_e state_q;
    state_e state_d;
    instr_e iclass;
    logic   mem_done;

`ifdef MC_MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done         = 1'b1;
`endif

    // Nop and every unsupported opcode/funct collapse into I_NONE: no writes, straight back to FETCH.
    always_comb begin
        iclass = I_NONE;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: iclass = I_ADDU;
                    FN_SUBU: iclass = I_SUBU;
                    FN_JR:   iclass = I_JR;
                    default: iclass = I_NONE;
                endcase
            end
            OP_J:    iclass = I_J;
            OP_JAL:  iclass = I_JAL;
            OP_BEQ:  iclass = I_BEQ;
            OP_ORI:  iclass = I_ORI;
            OP_LUI:  iclass = I_LUI;
            OP_LW:   iclass = I_LW;
            OP_SW:   iclass = I_SW;
            default: iclass = I_NONE;
        endcase
    end

    always_comb begin
        // NOTE: every output and state_d gets a default first so no path leaves one unassigned (no latches).
        state_d   = S_FETCH;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        reg_we    = 1'b0;
        mem_we    = 1'b0;
        alu_op    = ALU_ADD;
        alu_src_b = 1'b0;
        ext_op    = 1'b0;
        reg_dst   = DST_RT;
        wd_sel    = WD_ALU;
        npc_sel   = NPC_SEQ;

        case (state_q)
            S_FETCH: begin
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = S_DECODE;
            end

            S_DECODE: begin
                case (iclass)
                    I_J: begin
                        pc_we   = 1'b1;
                        npc_sel = NPC_JUMP;
                    end
                    I_JR: begin
                        pc_we   = 1'b1;
                        npc_sel = NPC_RS;
                    end
                    I_JAL: begin
                        // PC already holds PC+4 here, which is the link value.
                        pc_we   = 1'b1;
                        npc_sel = NPC_JUMP;
                        reg_we  = 1'b1;
                        reg_dst = DST_RA;
                        wd_sel  = WD_PC;
                    end
                    I_NONE:  state_d = S_FETCH;
                    default: state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                case (iclass)
                    I_ADDU: begin
                        alu_op  = ALU_ADD;
                        state_d = S_WB;
                    end
                    I_SUBU: begin
                        alu_op  = ALU_SUB;
                        state_d = S_WB;
                    end
                    I_ORI: begin
                        alu_op    = ALU_OR;
                        alu_src_b = 1'b1;
                        ext_op    = 1'b0;
                        state_d   = S_WB;
                    end
                    I_LUI: begin
                        alu_op    = ALU_LUI;
                        alu_src_b = 1'b1;
                        state_d   = S_WB;
                    end
                    I_LW, I_SW: begin
                        alu_op    = ALU_ADD;
                        alu_src_b = 1'b1;
                        ext_op    = 1'b1;
                        state_d   = S_MEM;
                    end
                    I_BEQ: begin
                        alu_op  = ALU_SUB;
                        ext_op  = 1'b1;
                        npc_sel = NPC_BRANCH;
                        pc_we   = zero;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                case (iclass)
                    I_SW: begin
                        mem_we  = 1'b1;
                        state_d = mem_done ? S_FETCH : S_MEM;
                    end
                    I_LW:    state_d = mem_done ? S_WB : S_MEM;
                    default: state_d = S_FETCH;
                endcase
            end

            S_WB: begin
                case (iclass)
                    I_ADDU, I_SUBU: begin
                        reg_we  = 1'b1;
                        reg_dst = DST_RD;
                        wd_sel  = WD_ALU;
                    end
                    I_ORI, I_LUI: begin
                        reg_we  = 1'b1;
                        reg_dst = DST_RT;
                        wd_sel  = WD_ALU;
                    end
                    I_LW: begin
                        reg_we  = 1'b1;
                        reg_dst = DST_RT;
                        wd_sel  = WD_DM;
                    end
                    default: reg_we = 1'b0;
                endcase
                state_d = S_FETCH;
            end

            default: state_d = S_FETCH;
        endcase

        instr_done = (state_d == S_FETCH);

        // Reset is asynchronous, so the enables must drop combinationally, not on the next edge.
        if (reset) begin
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            reg_we     = 1'b0;
            mem_we     = 1'b0;
            instr_done = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed test-plan steps, then random instruction streams
// compared cycle by cycle against a path-based reference model.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_we, ir_we, reg_we, mem_we;
    logic [1:0] alu_op;
    logic       alu_src_b, ext_op;
    logic [1:0] reg_dst, wd_sel, npc_sel;
    logic [2:0] state;
    logic       instr_done;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_we     (pc_we),
        .ir_we     (ir_we),
        .reg_we    (reg_we),
        .mem_we    (mem_we),
        .alu_op    (alu_op),
        .alu_src_b (alu_src_b),
        .ext_op    (ext_op),
        .reg_dst   (reg_dst),
        .wd_sel    (wd_sel),
        .npc_sel   (npc_sel),
        .state     (state),
        .instr_done(instr_done)
    );

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       reg_we;
        logic       mem_we;
        logic [1:0] alu_op;
        logic       alu_src_b;
        logic       ext_op;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic [1:0] npc_sel;
        logic       instr_done;
    } ctrl_t;

    typedef enum int {
        C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_NOP, C_BAD
    } cls_e;

    ctrl_t obs_ctrl;
    assign obs_ctrl = {pc_we, ir_we, reg_we, mem_we, alu_op, alu_src_b, ext_op,
                       reg_dst, wd_sel, npc_sel, instr_done};

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    function automatic int mem_waits(input int w);
`ifdef MC_MEM_WAIT_EN
        return w;
`else
        return 0 * w;
`endif
    endfunction

    // Instruction latency straight from the cycle-count table.
    function automatic int base_cycles(input cls_e c);
        case (c)
            C_J, C_JR, C_JAL, C_NOP, C_BAD:  return 2;
            C_BEQ:                           return 3;
            C_LW:                            return 5;
            default:                         return 4;
        endcase
    endfunction

    function automatic logic [11:0] encode(input cls_e c);
        logic [5:0] op;
        logic [5:0] fn;
        fn = 6'($urandom);
        case (c)
            C_ADDU: begin op = 6'h00; fn = 6'h21; end
            C_SUBU: begin op = 6'h00; fn = 6'h23; end
            C_JR:   begin op = 6'h00; fn = 6'h08; end
            C_NOP:  begin op = 6'h00; fn = 6'h00; end
            C_ORI:  op = 6'h0d;
            C_LUI:  op = 6'h0f;
            C_LW:   op = 6'h23;
            C_SW:   op = 6'h2b;
            C_BEQ:  op = 6'h04;
            C_J:    op = 6'h02;
            C_JAL:  op = 6'h03;
            default: begin
                op = 6'($urandom);
                if (op inside {6'h02, 6'h03, 6'h04, 6'h0d, 6'h0f, 6'h23, 6'h2b}) op = 6'h3f;
                if (op == 6'h00 && fn inside {6'h00, 6'h08, 6'h21, 6'h23}) fn = 6'h20;
            end
        endcase
        return {op, fn};
    endfunction

    // Expected controls for one cycle of an instruction, given the phase it is in.
    function automatic ctrl_t expect_ctrl(input cls_e c, input int st, input logic z, input logic last);
        ctrl_t e;
        e = '0;
        e.instr_done = last;
        case (st)
            0: begin e.pc_we = 1'b1; e.ir_we = 1'b1; end
            1: begin
                case (c)
                    C_J:   begin e.pc_we = 1'b1; e.npc_sel = 2'd2; end
                    C_JR:  begin e.pc_we = 1'b1; e.npc_sel = 2'd3; end
                    C_JAL: begin
                        e.pc_we = 1'b1; e.npc_sel = 2'd2;
                        e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wd_sel = 2'd2;
                    end
                    default: e.pc_we = 1'b0;
                endcase
            end
            2: begin
                case (c)
                    C_ADDU: e.alu_op = 2'd0;
                    C_SUBU: e.alu_op = 2'd1;
                    C_ORI:  begin e.alu_op = 2'd2; e.alu_src_b = 1'b1; end
                    C_LUI:  begin e.alu_op = 2'd3; e.alu_src_b = 1'b1; end
                    C_LW, C_SW: begin e.alu_src_b = 1'b1; e.ext_op = 1'b1; end
                    C_BEQ:  begin e.alu_op = 2'd1; e.ext_op = 1'b1; e.npc_sel = 2'd1; e.pc_we = z; end
                    default: e.alu_op = 2'd0;
                endcase
            end
            3: e.mem_we = (c == C_SW);
            4: begin
                e.reg_we  = 1'b1;
                e.reg_dst = (c == C_ADDU || c == C_SUBU) ? 2'd1 : 2'd0;
                e.wd_sel  = (c == C_LW) ? 2'd1 : 2'd0;
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    // Holds reset across an edge mid-cycle and releases it so the following cycle is a FETCH.
    task automatic pulse_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        check({tag, " async state"}, 32'(state), 32'd0);
        check({tag, " async ctrl"}, 32'(obs_ctrl), 32'd0);
        @(posedge clk);
        #1;
        check({tag, " held state"}, 32'(state), 32'd0);
        check({tag, " held ctrl"}, 32'(obs_ctrl), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Runs one instruction starting in its FETCH cycle; w = MEM stall cycles, abort_at = cycle to reset in.
    task automatic run_instr(input cls_e c, input logic [11:0] enc, input logic z,
                             input int w, input int abort_at);
        int   path[$];
        logic mr[$];
        int   done_at;
        int   wait_n;
        done_at = -1;
        wait_n  = mem_waits(w);
        path = {0, 1};
        mr.push_back(1'($urandom));
        mr.push_back(1'($urandom));
        if (!(c inside {C_J, C_JR, C_JAL, C_NOP, C_BAD})) begin
            path.push_back(2);
            mr.push_back(1'($urandom));
        end
        if (c == C_LW || c == C_SW) begin
            for (int k = 0; k < wait_n; k++) begin
                path.push_back(3);
                mr.push_back(1'b0);
            end
            path.push_back(3);
`ifdef MC_MEM_WAIT_EN
            mr.push_back(1'b1);
`else
            mr.push_back(1'($urandom));
`endif
        end
        if (c inside {C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW}) begin
            path.push_back(4);
            mr.push_back(1'($urandom));
        end

        for (int i = 0; i < path.size(); i++) begin
            @(negedge clk);
            if (i == 0) {opcode, funct} = enc;
            zero      = z;
            mem_ready = mr[i];
            #1;
            check($sformatf("%s cyc%0d state", c.name(), i), 32'(state), 32'(path[i]));
            check($sformatf("%s cyc%0d ctrl", c.name(), i), 32'(obs_ctrl),
                  32'(expect_ctrl(c, path[i], z, i == path.size() - 1)));
            if (instr_done === 1'b1 && done_at < 0) done_at = i + 1;
            if (i == abort_at) begin
                pulse_reset($sformatf("%s reset", c.name()));
                return;
            end
        end
        check($sformatf("%s cycles", c.name()), 32'(done_at), 32'(base_cycles(c) + wait_n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cls_e c;
        int   w;
        int   ab;

        repeat (3) begin
            @(negedge clk);
            #1;
            check("reset state", 32'(state), 32'd0);
            check("reset ctrl", 32'(obs_ctrl), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr(C_ADDU, encode(C_ADDU), 1'b0, 0, -1);
        run_instr(C_LW, encode(C_LW), 1'b0, 2, -1);
        run_instr(C_SW, encode(C_SW), 1'b0, 2, -1);
        run_instr(C_BEQ, encode(C_BEQ), 1'b1, 0, -1);
        run_instr(C_BEQ, encode(C_BEQ), 1'b0, 0, -1);
        run_instr(C_JAL, encode(C_JAL), 1'b0, 0, -1);
        run_instr(C_JR, encode(C_JR), 1'b0, 0, -1);
        run_instr(C_BAD, {6'h3f, 6'h00}, 1'b0, 0, -1);
        run_instr(C_ORI, encode(C_ORI), 1'b0, 0, 2);
        run_instr(C_NOP, encode(C_NOP), 1'b0, 0, -1);
        run_instr(C_SUBU, encode(C_SUBU), 1'b1, 0, -1);
        run_instr(C_LUI, encode(C_LUI), 1'b1, 0, -1);
        run_instr(C_J, encode(C_J), 1'b0, 0, -1);

        repeat (150) begin
            c  = cls_e'($urandom_range(0, 11));
            w  = $urandom_range(0, 3);
            ab = ($urandom_range(0, 19) == 0)
                 ? $urandom_range(0, base_cycles(c) + mem_waits(w) - 1) : -1;
            run_instr(c, encode(c), 1'($urandom), w, ab);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
